// File: rtl/key_sw_if.sv
// Load/store bus between the processor data path and key_sw_device.
// The processor drives address, data and strobes; the device returns data and sel.
interface key_sw_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] dIn;
    logic [DBITS-1:0] dOut;
    logic             wrtEn;
    logic             rdEn;
    logic             sel;

    modport master (
        output addr, dIn, wrtEn, rdEn,
        input  dOut, sel
    );

    modport slave (
        input  addr, dIn, wrtEn, rdEn,
        output dOut, sel
    );
endinterface

// File: rtl/key_sw_device.sv
// Memory-mapped KEY/SW responder: synchronizes and debounces the raw pins,
// and keeps sticky ready/overrun status for each input bus.
module key_sw_debounce #(
    parameter int W  = 4,
    parameter int DC = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] deb_o,
    output logic         evt_o
);
    localparam int CW = (DC > 1) ? $clog2(DC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DC - 1);

    logic [W-1:0]  s1_q, s2_q, s3_q;
    logic [W-1:0]  deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        deb_d = deb_q;
        evt_o = 1'b0;
        // Any movement, or agreement with the accepted value, restarts the count
        if ((s2_q != s3_q) || (s2_q == deb_q)) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            deb_d = s2_q;
            cnt_d = '0;
            evt_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module key_sw_device #(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     key,
    input  logic [9:0]     sw,
    key_sw_if.slave        bus
);
    logic [3:0] deb_key;
    logic [9:0] deb_sw;
    logic       evt_key, evt_sw;

    logic k_rdy_q, k_rdy_d, k_ovr_q, k_ovr_d;
    logic s_rdy_q, s_rdy_d, s_ovr_q, s_ovr_d;

    logic hit_kd, hit_sd, hit_kc, hit_sc;
    logic k_rclr, s_rclr, k_wr, s_wr;
    logic k_clr, s_clr;

    // KEY pins are active-low; internally 1 means pressed
    key_sw_debounce #(.W(4), .DC(DEBOUNCE_CYCLES)) u_key (
        .clk   (clk),
        .reset (reset),
        .raw_i (~key),
        .deb_o (deb_key),
        .evt_o (evt_key)
    );

    key_sw_debounce #(.W(10), .DC(DEBOUNCE_CYCLES)) u_sw (
        .clk   (clk),
        .reset (reset),
        .raw_i (sw),
        .deb_o (deb_sw),
        .evt_o (evt_sw)
    );

    assign hit_kd = bus.addr[DBITS-1:2] == ADDR_KDATA[DBITS-1:2];
    assign hit_sd = bus.addr[DBITS-1:2] == ADDR_SDATA[DBITS-1:2];
    assign hit_kc = bus.addr[DBITS-1:2] == ADDR_KCTRL[DBITS-1:2];
    assign hit_sc = bus.addr[DBITS-1:2] == ADDR_SCTRL[DBITS-1:2];

    assign bus.sel = hit_kd | hit_sd | hit_kc | hit_sc;

    always_comb begin
        bus.dOut = '0;
        unique case (1'b1)
            hit_kd:  bus.dOut = {{(DBITS-4){1'b0}}, deb_key};
            hit_sd:  bus.dOut = {{(DBITS-10){1'b0}}, deb_sw};
            hit_kc:  bus.dOut = {{(DBITS-3){1'b0}}, k_ovr_q, 1'b0, k_rdy_q};
            hit_sc:  bus.dOut = {{(DBITS-3){1'b0}}, s_ovr_q, 1'b0, s_rdy_q};
            default: bus.dOut = '0;
        endcase
    end

    assign k_rclr = bus.rdEn & hit_kd;
    assign s_rclr = bus.rdEn & hit_sd;
    assign k_wr   = bus.wrtEn & hit_kc;
    assign s_wr   = bus.wrtEn & hit_sc;

    // rdy counts as cleared this edge by either a data read or a zero write
    assign k_clr = k_rclr | (k_wr & ~bus.dIn[0]);
    assign s_clr = s_rclr | (s_wr & ~bus.dIn[0]);

    always_comb begin
        k_rdy_d = k_rdy_q & ~k_rclr;
        k_ovr_d = k_ovr_q;
        if (k_wr) begin
            k_rdy_d = k_rdy_d & bus.dIn[0];
            k_ovr_d = k_ovr_q & bus.dIn[2];
        end
        if (evt_key) begin
            k_rdy_d = 1'b1;
        end
        if (evt_key && k_rdy_q && !k_clr) begin
            k_ovr_d = 1'b1;
        end
    end

    always_comb begin
        s_rdy_d = s_rdy_q & ~s_rclr;
        s_ovr_d = s_ovr_q;
        if (s_wr) begin
            s_rdy_d = s_rdy_d & bus.dIn[0];
            s_ovr_d = s_ovr_q & bus.dIn[2];
        end
        if (evt_sw) begin
            s_rdy_d = 1'b1;
        end
        if (evt_sw && s_rdy_q && !s_clr) begin
            s_ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_rdy_q <= 1'b0;
            k_ovr_q <= 1'b0;
            s_rdy_q <= 1'b0;
            s_ovr_q <= 1'b0;
        end else begin
            k_rdy_q <= k_rdy_d;
            k_ovr_q <= k_ovr_d;
            s_rdy_q <= s_rdy_d;
            s_ovr_q <= s_ovr_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.dIn[DBITS-1:3], bus.dIn[1]};
endmodule
